uart_msg_formatter: RTL
=======================

Name: uart_msg_formatter

Overview:
Upstream feeder for the UART transmitter. On a button press it captures the 8-bit random value and converts it to three ASCII decimal digits. It then streams the line "RANDOM NUMBER: ddd\r\n" one byte at a time to the TX serializer over a valid/ready byte interface. This moves message and number formatting out of the transmitter, which then only serializes bytes.

Parameters:
DEBOUNCE_CYCLES, 262143, holdoff cycles after a message before the button is re-examined for release
BTN_SYNC_STAGES, 2, synchronizer flops on btn_n (min 2)

Ports:
clk  input  1  system clock (27 MHz)
rst  input  1  reset; synchronous, active-high
btn_n  input  1  trigger button, active-low, asynchronous to clk
value  input  8  random number source; sampled only at trigger
tx_data  output  8  ASCII byte to transmitter
tx_valid  output  1  tx_data holds a byte to send
tx_ready  input  1  transmitter accepts tx_data this cycle
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the last byte is accepted

Behaviour:
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, done=0, state=IDLE, byte index=0, synchronizer flops=1 (released).
- Reset is synchronous. Asserting rst mid-conversion or mid-stream aborts at that edge. tx_valid is 0 from the following cycle. No partial-message resume.
- btn_n passes through BTN_SYNC_STAGES flops. Trigger is a falling edge of the synchronized signal, detected in IDLE only.
- States: IDLE -> CONVERT -> SEND -> HOLDOFF -> IDLE.
- IDLE: on trigger, latch value into an 8-bit capture register and clear the BCD accumulator. Go to CONVERT.
- CONVERT: shift-add-3 (double dabble), one bit per cycle, exactly 8 cycles. Result is hundreds (0-2), tens and ones (0-9).
- ASCII digit = 8'h30 + BCD digit. Leading zeros are kept: 7 -> "007", 0 -> "000".
- SEND: byte index 0..19 selects the byte:
  - indices 0-14: "RANDOM NUMBER: "
  - index 15: hundreds digit; 16: tens digit; 17: ones digit
  - index 18: 8'h0D; index 19: 8'h0A
- Handshake: a byte transfers on a cycle with tx_valid && tx_ready.
  - Once tx_valid is raised, tx_data and tx_valid hold until that transfer. tx_valid never drops without a transfer, except on rst.
  - After a transfer, the next byte is presented the next cycle (tx_valid may stay high).
  - tx_ready may be low indefinitely.
- First byte: tx_valid rises on the cycle after CONVERT completes. Trigger-to-first-tx_valid latency = 9 cycles after the synchronized edge.
- Transfer of index 19: done pulses high for exactly that cycle, tx_valid=0 next cycle, go to HOLDOFF.
- HOLDOFF: counter runs 0..DEBOUNCE_CYCLES, then waits for synchronized btn_n=1, then IDLE.
  - A button still held keeps the block in HOLDOFF.
  - Presses during CONVERT, SEND or HOLDOFF are ignored and never queued.
- value changes after capture do not affect the message in flight.
- Byte index width is 5 bits and never wraps past the last message byte. The holdoff counter is sized from DEBOUNCE_CYCLES.

Optional Feature:
Macro MSG_HEX_EN.
- Defined: " 0x" plus two uppercase hex digits of the captured value are inserted before CR LF, making a 25-byte message. Indices 18-22 are ' ', '0', 'x', hi nibble, lo nibble; 23=CR, 24=LF; done fires on index 24.
- Hex digit 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10).
- Undefined: 20-byte message, no hex logic present.

Test Plan:
- value=8'hA5, tx_ready tied 1, press btn_n -> 20 bytes "RANDOM NUMBER: 165" 0D 0A, one per cycle, done pulse on the 0A transfer.
- value=8'h07, then 8'hFF, then 8'h00 -> digits "007", "255", "000" respectively.
- Backpressure: tx_ready toggles pseudo-randomly, low for up to 50 cycles -> tx_data/tx_valid stable while stalled, exact byte order, no drops or duplicates.
- Button held through the whole message plus 2*DEBOUNCE_CYCLES (DEBOUNCE_CYCLES=100 in sim) -> exactly one message. Release then re-press -> a second message.
- rst asserted on the transfer cycle of byte index 8 -> tx_valid=0 and busy=0 next cycle. A new press sends a full message from 'R'.
- MSG_HEX_EN defined, value=8'h3C -> "RANDOM NUMBER: 060 0x3C" 0D 0A, 25 bytes, done on the final 0A.

Source files
------------

// File: rtl/uart_msg_formatter_if.sv
// -----------------------------------------------------------------------------
// uart_msg_formatter_if
// Byte stream from the message formatter to the UART TX serializer.
//   tx_data  : ASCII byte offered to the transmitter
//   tx_valid : tx_data holds a byte to send
//   tx_ready : transmitter accepts tx_data this cycle
// Modports: master (formatter side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface uart_msg_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_msg_formatter.sv
// -----------------------------------------------------------------------------
// uart_msg_formatter
// On a falling edge of the synchronized button, captures an 8-bit value,
// converts it to three decimal digits (double dabble, 8 cycles) and streams
// "RANDOM NUMBER: ddd\r\n" byte by byte over a valid/ready interface.
// Afterwards it waits out a holdoff period and for the button to be released.
//
// Ports:
//   clk    : system clock
//   rst    : synchronous, active-high reset
//   btn_n  : trigger button, active-low, asynchronous to clk
//   value  : number to print, sampled only at the trigger
//   tx     : byte stream to the transmitter (master modport)
//   busy   : high whenever the block is not IDLE
//   done   : one-cycle pulse on the cycle the last byte is accepted
//
// Build option: define MSG_HEX_EN to append " 0xHH" (uppercase hex of the
// captured value) before CR LF, giving a 25-byte message instead of 20.
// -----------------------------------------------------------------------------
module uart_msg_formatter #(
  parameter int DEBOUNCE_CYCLES = 262143,
  parameter int BTN_SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_n,
  input  logic [7:0]           value,
  uart_msg_formatter_if.master tx,
  output logic                 busy,
  output logic                 done
);

`ifdef MSG_HEX_EN
  localparam logic [4:0] LAST_IDX = 5'd24;
`else
  localparam logic [4:0] LAST_IDX = 5'd19;
`endif
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, SEND, HOLDOFF} state_t;

  state_t                     state_q, state_d;
  logic [BTN_SYNC_STAGES-1:0] sync_q;
  logic                       btn_prev_q;
  logic [7:0]                 cap_q;
  logic [11:0]                bcd_q;       // {hundreds, tens, ones}
  logic [11:0]                bcd_adj;
  logic [2:0]                 bit_cnt_q;
  logic [4:0]                 idx_q;
  logic [4:0]                 sel_idx;
  logic [CNT_W-1:0]           hold_cnt_q;
  logic [7:0]                 tx_data_q;
  logic                       tx_valid_q;
  logic [7:0]                 msg_byte;

  logic btn_sync, trigger, xfer, last_xfer, convert_last, hold_done;

  assign btn_sync     = sync_q[BTN_SYNC_STAGES-1];
  assign trigger      = (state_q == IDLE) && btn_prev_q && !btn_sync;
  assign xfer         = tx_valid_q && tx.tx_ready;
  assign last_xfer    = (state_q == SEND) && xfer && (idx_q == LAST_IDX);
  assign convert_last = (state_q == CONVERT) && (bit_cnt_q == 3'd7);
  assign hold_done    = (hold_cnt_q == CNT_W'(DEBOUNCE_CYCLES));

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

`ifdef MSG_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 == 8'h37
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
`endif

  // Double dabble: adjust every BCD nibble >= 5 before each left shift.
  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  // The byte loaded into tx_data is always the one after the current index,
  // or index 0 when the stream is being started from CONVERT.
  assign sel_idx = (state_q == SEND) ? idx_q + 5'd1 : 5'd0;

  always_comb begin
    msg_byte = 8'h00;
    case (sel_idx)
      5'd0:  msg_byte = "R";
      5'd1:  msg_byte = "A";
      5'd2:  msg_byte = "N";
      5'd3:  msg_byte = "D";
      5'd4:  msg_byte = "O";
      5'd5:  msg_byte = "M";
      5'd6:  msg_byte = " ";
      5'd7:  msg_byte = "N";
      5'd8:  msg_byte = "U";
      5'd9:  msg_byte = "M";
      5'd10: msg_byte = "B";
      5'd11: msg_byte = "E";
      5'd12: msg_byte = "R";
      5'd13: msg_byte = ":";
      5'd14: msg_byte = " ";
      5'd15: msg_byte = 8'h30 + {4'h0, bcd_q[11:8]};
      5'd16: msg_byte = 8'h30 + {4'h0, bcd_q[7:4]};
      5'd17: msg_byte = 8'h30 + {4'h0, bcd_q[3:0]};
`ifdef MSG_HEX_EN
      5'd18: msg_byte = " ";
      5'd19: msg_byte = "0";
      5'd20: msg_byte = "x";
      5'd21: msg_byte = hex_ascii(cap_q[7:4]);
      5'd22: msg_byte = hex_ascii(cap_q[3:0]);
      5'd23: msg_byte = 8'h0D;
      5'd24: msg_byte = 8'h0A;
`else
      5'd18: msg_byte = 8'h0D;
      5'd19: msg_byte = 8'h0A;
`endif
      default: msg_byte = 8'h00;
    endcase
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = last_xfer;
    case (state_q)
      IDLE:    if (trigger)                state_d = CONVERT;
      CONVERT: if (convert_last)           state_d = SEND;
      SEND:    if (last_xfer)              state_d = HOLDOFF;
      HOLDOFF: if (hold_done && btn_sync)  state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      btn_prev_q <= 1'b1;
      cap_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[BTN_SYNC_STAGES-2:0], btn_n};
      btn_prev_q <= btn_sync;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            cap_q     <= value;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        CONVERT: begin
          // Shift the captured value in MSB first.
          bcd_q     <= (bcd_adj << 1) | {11'd0, cap_q[3'd7 - bit_cnt_q]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (convert_last) begin
            idx_q      <= '0;
            tx_data_q  <= msg_byte;
            tx_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              hold_cnt_q <= '0;
            end else begin
              idx_q     <= idx_q + 5'd1;
              tx_data_q <= msg_byte;
            end
          end
        end
        HOLDOFF: begin
          if (!hold_done) hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
